// File: rtl/mdu_hilo_writer_if.sv
// Issue/writeback bus between EX and the multiply/divide unit that feeds the HI/LO register file.
// The master (EX side) issues operations; the slave (MDU) drives busy and the HI/LO write port.
interface mdu_hilo_writer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             busy;
    logic             ena_hi;
    logic             ena_lo;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;

    modport master (
        output start, op, src_a, src_b, cancel,
        input  busy, ena_hi, ena_lo, o_hi, o_lo
    );

    modport slave (
        input  start, op, src_a, src_b, cancel,
        output busy, ena_hi, ena_lo, o_hi, o_lo
    );
endinterface

// File: rtl/mdu_hilo_writer.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO unit driving the HI/LO register file write port.
// Optional macro MDU_FAST_MUL_EN: single-cycle registered multiplier (IDLE -> CALC -> WB).
module mdu_hilo_writer #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                resetn,
    mdu_hilo_writer_if.slave    bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int W2 = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t           state_r, next_state_s;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r, d_r, o_hi_r, o_lo_r;
    logic [W2-1:0]    acc_r;
    logic [CW-1:0]    cnt_r;
    logic             neg_q_r, neg_r_r, wr_hi_r, wr_lo_r;

    logic             accept_s, is_mul_s, is_signed_s, b_zero_s;
    logic [WIDTH-1:0] a_abs_s, b_abs_s, hi_fix_s, lo_fix_s;
    logic [W2-1:0]    mul_next_s, div_next_s, prod_s;
    logic [WIDTH:0]   mul_sum_s, rem_sh_s, diff_s;
`ifdef MDU_FAST_MUL_EN
    logic [W2-1:0]    prod_fast_s;
`endif

    assign accept_s    = (state_r == S_IDLE) & bus.start & ~bus.cancel & (bus.op <= 3'd5);
    assign is_mul_s    = (op_r == OP_MULT) | (op_r == OP_MULTU);
    assign is_signed_s = (op_r == OP_MULT) | (op_r == OP_DIV);
    assign b_zero_s    = (b_r == {WIDTH{1'b0}});

    // Operand magnitudes, one shift-add step, one restoring-divide step and sign fixup.
    always_comb begin
        a_abs_s    = (is_signed_s & a_r[WIDTH-1]) ? (~a_r + WIDTH'(1)) : a_r;
        b_abs_s    = (is_signed_s & b_r[WIDTH-1]) ? (~b_r + WIDTH'(1)) : b_r;
        mul_sum_s  = {1'b0, acc_r[W2-1:WIDTH]} + (acc_r[0] ? {1'b0, d_r} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        rem_sh_s   = {acc_r[W2-1:WIDTH], acc_r[WIDTH-1]};
        diff_s     = rem_sh_s - {1'b0, d_r};
        if (!diff_s[WIDTH]) begin
            div_next_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
        prod_s = neg_q_r ? (~acc_r + W2'(1)) : acc_r;
        if (is_mul_s) begin
            hi_fix_s = prod_s[W2-1:WIDTH];
            lo_fix_s = prod_s[WIDTH-1:0];
        end else if (b_zero_s) begin
            // Divide by zero: all-ones quotient, untouched dividend as remainder.
            hi_fix_s = a_r;
            lo_fix_s = {WIDTH{1'b1}};
        end else begin
            hi_fix_s = neg_r_r ? (~acc_r[W2-1:WIDTH] + WIDTH'(1)) : acc_r[W2-1:WIDTH];
            lo_fix_s = neg_q_r ? (~acc_r[WIDTH-1:0] + WIDTH'(1)) : acc_r[WIDTH-1:0];
        end
    end

`ifdef MDU_FAST_MUL_EN
    // Full-width product of sign- or zero-extended operands; low 2*WIDTH bits are exact either way.
    always_comb begin
        prod_fast_s = {{WIDTH{is_signed_s & a_r[WIDTH-1]}}, a_r} * {{WIDTH{is_signed_s & b_r[WIDTH-1]}}, b_r};
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; cancel aborts every in-flight state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if ((bus.op == OP_MTHI) || (bus.op == OP_MTLO)) begin
                        next_state_s = S_WB;
`ifdef MDU_FAST_MUL_EN
                    end else if ((bus.op == OP_MULT) || (bus.op == OP_MULTU)) begin
                        next_state_s = S_CALC;
`endif
                    end else begin
                        next_state_s = S_PREP;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_PREP: next_state_s = bus.cancel ? S_IDLE : S_CALC;
            S_CALC: begin
                if (bus.cancel) begin
                    next_state_s = S_IDLE;
`ifdef MDU_FAST_MUL_EN
                end else if (is_mul_s) begin
                    next_state_s = S_WB;
`endif
                end else if (cnt_r == CW'(WIDTH - 1)) begin
                    next_state_s = S_FIX;
                end else begin
                    next_state_s = S_CALC;
                end
            end
            S_FIX:   next_state_s = bus.cancel ? S_IDLE : S_WB;
            S_WB:    next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and HI/LO write data registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_r    <= 3'd0;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            d_r     <= {WIDTH{1'b0}};
            acc_r   <= {W2{1'b0}};
            cnt_r   <= {CW{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            wr_hi_r <= 1'b0;
            wr_lo_r <= 1'b0;
            o_hi_r  <= {WIDTH{1'b0}};
            o_lo_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        op_r    <= bus.op;
                        a_r     <= bus.src_a;
                        b_r     <= bus.src_b;
                        wr_hi_r <= (bus.op != OP_MTLO);
                        wr_lo_r <= (bus.op != OP_MTHI);
                        if (bus.op == OP_MTHI) o_hi_r <= bus.src_a;
                        if (bus.op == OP_MTLO) o_lo_r <= bus.src_a;
                    end
                end
                S_PREP: begin
                    neg_q_r <= is_signed_s & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    neg_r_r <= is_signed_s & a_r[WIDTH-1];
                    d_r     <= is_mul_s ? a_abs_s : b_abs_s;
                    acc_r   <= {{WIDTH{1'b0}}, (is_mul_s ? b_abs_s : a_abs_s)};
                    cnt_r   <= {CW{1'b0}};
                end
                S_CALC: begin
`ifdef MDU_FAST_MUL_EN
                    if (is_mul_s) begin
                        if (!bus.cancel) begin
                            o_hi_r <= prod_fast_s[W2-1:WIDTH];
                            o_lo_r <= prod_fast_s[WIDTH-1:0];
                        end
                    end else begin
                        acc_r <= div_next_s;
                        cnt_r <= cnt_r + CW'(1);
                    end
`else
                    acc_r <= is_mul_s ? mul_next_s : div_next_s;
                    cnt_r <= cnt_r + CW'(1);
`endif
                end
                S_FIX: begin
                    if (!bus.cancel) begin
                        o_hi_r <= hi_fix_s;
                        o_lo_r <= lo_fix_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy   = (state_r != S_IDLE);
    assign bus.ena_hi = (state_r == S_WB) & wr_hi_r & ~bus.cancel;
    assign bus.ena_lo = (state_r == S_WB) & wr_lo_r & ~bus.cancel;
    assign bus.o_hi   = o_hi_r;
    assign bus.o_lo   = o_lo_r;
endmodule

// File: doc/mdu_hilo_writer.md
Name: mdu_hilo_writer

Overview:
- Iterative MIPS multiply/divide unit and the write side of the HI/LO register pair.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO issued by EX.
- Drives the HI/LO register file write port: ena_hi, ena_lo and the i_hi/i_lo data.
- Holds busy high so the pipeline stalls while an operation is in flight.

Parameters:
- WIDTH, 32, operand/result width. Iteration count equals WIDTH; only 32 is verified.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  issue request; accepted only when state==IDLE and op is valid
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 are never accepted
- src_a  in  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO data)
- src_b  in  WIDTH  rt operand (multiplier/divisor)
- cancel  in  1  pipeline flush; aborts any operation in flight
- busy  out  1  high in every state except IDLE
- ena_hi  out  1  HI write enable to the register file
- ena_lo  out  1  LO write enable to the register file
- o_hi  out  WIDTH  HI write data (register file i_hi)
- o_lo  out  WIDTH  LO write data (register file i_lo)

Behaviour:
- Reset (resetn low, takes effect immediately):
  - state=IDLE.
  - All internal registers cleared.
  - busy, ena_hi, ena_lo = 0; o_hi, o_lo = 0.
  - Reset mid-operation discards the operation; no write occurs.
- State machine: IDLE, PREP, CALC, FIX, WB.
- Accept: in IDLE, when start=1, cancel=0 and op<=5, operands and op are captured on the edge. The accept cycle is cycle 0.
- MTHI/MTLO path:
  - IDLE -> WB.
  - Cycle 1: o_hi=src_a with ena_hi=1 only (MTHI), or o_lo=src_a with ena_lo=1 only (MTLO).
- MUL/DIV path:
  - IDLE -> PREP: signed ops take absolute values and record result signs.
  - PREP -> CALC: 32 iterations.
    - Multiply: shift-add into a 64-bit accumulator.
    - Divide: restoring, one quotient bit per cycle.
  - CALC -> FIX: apply signs.
  - FIX -> WB.
  - WB is cycle 35; ena_hi=ena_lo=1 for exactly that one cycle.
- Multiply results: {o_hi, o_lo} = 64-bit product, two's complement for MULT.
- Divide results: o_lo = quotient, truncated toward zero; o_hi = remainder, which takes the sign of the dividend.
- Divide boundary cases:
  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
  - Divisor 0: lo=0xFFFFFFFF, hi=src_a, for both DIV and DIVU; no sign fixup applied.
- Output hold: o_hi/o_lo are valid only in WB and hold their last value otherwise. ena_* are 0 outside WB.
- Cancel:
  - In PREP/CALC/FIX: state returns to IDLE on the next edge; no ena pulse is produced.
  - In WB: ena_*=0 combinationally, and the state returns to IDLE.
  - Cancel together with start in IDLE: start is ignored.
- WB -> IDLE unconditionally. start is ignored while busy=1.
- Back-to-back: a new start may be accepted in the first IDLE cycle after WB.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined:
  - MULT/MULTU use a single-cycle registered array multiplier.
  - Path: IDLE -> CALC for one cycle (product registered) -> WB.
  - ena_* asserted at cycle 2; PREP and FIX are skipped.
  - Divide path unchanged.
- Undefined: multiply uses the iterative path described above, with WB at cycle 35.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> WB at cycle 35 (cycle 2 with MDU_FAST_MUL_EN) with hi=0xFFFFFFFE, lo=0x00000001; busy=1 for cycles 1..35.
- MULT 0xFFFFFFFD x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x00000064 / 0 -> lo=0xFFFFFFFF, hi=0x00000064; exactly one ena pulse.
- MTHI 0x12345678 -> cycle 1: ena_hi=1, ena_lo=0, o_hi=0x12345678. A start on the same cycle as the WB is not accepted; the same start one cycle later is accepted.
- Two abort cases:
  - DIVU 1000/3 with cancel asserted at cycle 10 -> no ena pulse, busy=0 at cycle 11.
  - resetn pulled low at cycle 20 of a MULT -> busy, ena_* and o_* are 0 immediately, and no write occurs after reset is released.
